bfp_stage_bw_detect: RTL
========================

Name: bfp_stage_bw_detect

Overview:
- Upstream feeder of the BFP bit-width accumulator in the streaming FFT.
- Watches one complete FFT pass of complex samples, either raw ADC data or butterfly outputs. For each sample it computes the significant bit width and tracks the maximum over the frame.
- At frame end it emits the init/bw_init pulse (ADC pass) or the update/bw_new pulse (butterfly pass) that the accumulator consumes.

Parameters:
- FFT_DW, 16, signed width of in_re/in_im.
- FFT_MAX_BIT_WIDTH, 5, width of the bit-width outputs; must satisfy 2^FFT_MAX_BIT_WIDTH > FFT_DW.
- N_SAMPLES, 1024, complex samples per frame (one FFT pass); must be >= 2.
- CNT_W, $clog2(N_SAMPLES), sample counter width (derived).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse that opens a frame
- src_adc  in  1  sampled with frame_start; 1 = ADC pass (report via init), 0 = butterfly pass (report via update)
- in_valid  in  1  sample strobe
- in_re  in  FFT_DW  signed real part
- in_im  in  FFT_DW  signed imaginary part
- in_ovf  in  1  butterfly saturated this sample
- busy  out  1  frame open, counting samples
- sample_cnt  out  CNT_W  samples accepted in current frame
- init  out  1  one-cycle pulse, ADC frame result
- bw_init  out  FFT_MAX_BIT_WIDTH  max width of ADC frame, valid with init
- update  out  1  one-cycle pulse, butterfly frame result
- bw_new  out  FFT_MAX_BIT_WIDTH  max width of butterfly frame, valid with update

Behaviour:
- Reset (async, reset_n=0): busy=0, sample_cnt=0, init=0, update=0, bw_init=0, bw_new=0, internal max=0, pipeline valid bits=0. Reset mid-frame discards the frame and produces no pulse.
- Per-value width w(x), combinational:
  - x==0 or x==-1: w=0.
  - Otherwise: 1 + index of the highest bit differing from the sign bit, range 1..FFT_DW-1. Examples: +1→1, -2→1, +255→8, -256→8, +32767→15, -32768→15.
- Sample width: max(w(in_re), w(in_im)). If in_ovf=1, the sample width is forced to FFT_DW.
- Accept rule: a sample is accepted when in_valid=1, busy=1 and frame_start=0. in_valid with busy=0 is ignored.
- Pipeline:
  - Edge E accepts a sample and registers its width.
  - Edge E+1 folds that width into the running max.
  - For the last sample (sample_cnt == N_SAMPLES-1 at E), edge E+1 loads the output register with max(running_max, last width). The init or update pulse is high during the cycle after E+1.
  - Latency: 2 edges from the last accept to the pulse. The pulse lasts exactly 1 cycle.
- Output registers:
  - bw_init and bw_new hold their value until the next report of the same type.
  - init and update are never high together.
  - src_adc is latched at frame_start and selects which pulse fires.
- Frame control:
  - frame_start with busy=0: busy←1, sample_cnt←0, running max←0, src latched.
  - busy drops at edge E (last accept); sample_cnt returns to 0 there.
- Boundary conditions:
  - Back-to-back frames: frame_start is legal from the cycle right after E. The in-flight result of the previous frame is still reported, because the output stage reads the old max and width registers at the same edge that clears them.
  - frame_start while busy=1: abort. The count restarts, max is cleared, src is re-latched, and no pulse is issued for the aborted frame. A pending last-sample pipeline entry is unaffected.
  - frame_start and in_valid in the same cycle: frame_start wins and the sample is dropped.
  - Counter wraps only through end-of-frame; it never exceeds N_SAMPLES-1.
- Width of every sample and of the max is saturated to FFT_DW (fits FFT_MAX_BIT_WIDTH).

Decomposition:
- Package bfp_pkg holds:
  - constants FFT_DW and FFT_MAX_BIT_WIDTH;
  - typedef bw_t = logic [FFT_MAX_BIT_WIDTH-1:0];
  - typedef sample_t = logic signed [FFT_DW-1:0];
  - function sig_width(sample_t) returning bw_t.
- One sub-module, bfp_sample_bw: combinational width of re/im/ovf to bw_t. It is instantiated once and unit-testable alone.

Test Plan (N_SAMPLES=8 unless noted):
- ADC frame: frame_start with src_adc=1; 8 samples re/im in {0,-1} except sample 5 re=+255 → init high one cycle, exactly 2 edges after the 8th accept; bw_init=8; update stays 0.
- Butterfly frame: src_adc=0; samples include im=-32768 at sample 0 → update pulse, bw_new=15. Repeat with in_ovf=1 on sample 7 → bw_new=16.
- Back-to-back: second frame_start (src_adc=0) in the cycle after the first frame's last accept, second frame max=3 → first pulse init/bw_init=8 unaffected, then update/bw_new=3 after the second frame.
- Abort: frame_start at sample 4 with large values already seen (re=+1000), new frame all widths ≤2 → only one pulse, value 2.
- Ignore/collision: in_valid while busy=0 → sample_cnt stays 0; frame_start and in_valid in the same cycle → that sample is not counted.
- Async reset: assert reset_n=0 mid-frame between clock edges → outputs are 0 immediately; no pulse after release; the next full frame reports correctly.

Source files
------------

// File: rtl/bfp_pkg.sv
// Shared widths, types and the per-value significant-width helper for the BFP
// bit-width detection path.
package bfp_pkg;

    localparam int FFT_DW            = 16;
    localparam int FFT_MAX_BIT_WIDTH = 5;

    typedef logic [FFT_MAX_BIT_WIDTH-1:0] bw_t;
    typedef logic signed [FFT_DW-1:0]     sample_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } frame_st_t;

    localparam bw_t BW_SAT = bw_t'(FFT_DW);

    // Fold the sign into the magnitude bits so 0 and -1 both give width 0.
    function automatic bw_t sig_width(input sample_t x);
        logic [FFT_DW-1:0] w_mag;
        bw_t               w_bw;
        w_mag = x ^ {FFT_DW{x[FFT_DW-1]}};
        w_bw  = '0;
        for (int i = 0; i < FFT_DW - 1; i++) begin
            if (w_mag[i]) w_bw = bw_t'(i + 1);
        end
        return w_bw;
    endfunction

    function automatic bw_t bw_max(input bw_t a, input bw_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bfp_sample_bw.sv
// Combinational significant width of one complex sample; a saturated butterfly
// result forces the full data width.
module bfp_sample_bw
    import bfp_pkg::*;
(
    input  sample_t i_re,
    input  sample_t i_im,
    input  logic    i_ovf,
    output bw_t     o_bw
);

    bw_t w_re_bw;
    bw_t w_im_bw;

    always_comb begin
        w_re_bw = sig_width(i_re);
        w_im_bw = sig_width(i_im);
        o_bw    = i_ovf ? BW_SAT : bw_max(w_re_bw, w_im_bw);
    end

endmodule

// File: rtl/bfp_stage_bw_detect.sv
// Tracks the maximum sample bit width over one FFT pass and reports it as an
// init (ADC pass) or update (butterfly pass) pulse for the BFP accumulator.
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | no frame open, samples ignored
// ST_BUSY | frame open, counting accepted samples
module bfp_stage_bw_detect
    import bfp_pkg::*;
#(
    parameter int N_SAMPLES = 1024,
    parameter int CNT_W     = $clog2(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic             src_adc,
    input  logic             in_valid,
    input  sample_t          in_re,
    input  sample_t          in_im,
    input  logic             in_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             init,
    output bw_t              bw_init,
    output logic             update,
    output bw_t              bw_new
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    frame_st_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_src;

    bw_t              r_max;
    logic             r_s1_vld;
    logic             r_s1_last;
    logic             r_s1_src;
    bw_t              r_s1_bw;

    logic             r_init;
    logic             r_update;
    bw_t              r_bw_init;
    bw_t              r_bw_new;

    logic             w_accept;
    logic             w_last;
    bw_t              w_sample_bw;
    bw_t              w_fold;

    bfp_sample_bw u_sample_bw (
        .i_re  (in_re),
        .i_im  (in_im),
        .i_ovf (in_ovf),
        .o_bw  (w_sample_bw)
    );

    assign w_accept = in_valid && (r_state == ST_BUSY) && !frame_start;
    assign w_last   = w_accept && (r_cnt == LAST_IDX);
    assign w_fold   = bw_max(r_max, r_s1_bw);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_src   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= '0;
                        r_src   <= src_adc;
                    end
                end
                ST_BUSY: begin
                    if (frame_start) begin
                        r_cnt <= '0;
                        r_src <= src_adc;
                    end else if (w_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Source travels with the last sample so a back-to-back frame_start that
    // re-latches r_src cannot redirect the previous frame's report.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_src  <= 1'b0;
            r_s1_bw   <= '0;
            r_max     <= '0;
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_last <= w_last;
            r_s1_src  <= r_src;
            if (w_accept) r_s1_bw <= w_sample_bw;
            if (frame_start)   r_max <= '0;
            else if (r_s1_vld) r_max <= w_fold;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init    <= 1'b0;
            r_update  <= 1'b0;
            r_bw_init <= '0;
            r_bw_new  <= '0;
        end else begin
            r_init   <= r_s1_last && r_s1_src;
            r_update <= r_s1_last && !r_s1_src;
            if (r_s1_last && r_s1_src)  r_bw_init <= w_fold;
            if (r_s1_last && !r_s1_src) r_bw_new  <= w_fold;
        end
    end

    assign busy       = (r_state == ST_BUSY);
    assign sample_cnt = r_cnt;
    assign init       = r_init;
    assign update     = r_update;
    assign bw_init    = r_bw_init;
    assign bw_new     = r_bw_new;

endmodule
